// File: rtl/inst_issue_unit.sv
// Instruction issue unit: loadable program memory plus a program counter that
// feeds one registered instruction per clock to the core, with stall and an
// end-of-program done pulse.
module inst_issue_unit #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 1 << ADDR_W,
  parameter int unsigned INST_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              start,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   issue_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  logic [INST_W-1:0] mem [DEPTH];
  logic [INST_W-1:0] word;
  // Set once the last memory word has issued; the next unstalled edge then
  // ends the program exactly as an end-of-program marker would.
  logic              wrapped;

  assign word = mem[pc];

  // Program memory: written only while idle, never cleared by reset.
  always_ff @(posedge clock) begin
    if (state == IDLE && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Issue FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      inst        <= '0;
      inst_valid  <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_count <= '0;
      wrapped     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            pc          <= '0;
            issue_count <= '0;
            wrapped     <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (wrapped || word == '0) begin
              state      <= HALT;
              busy       <= 1'b0;
              done       <= 1'b1;
              inst       <= '0;
              inst_valid <= 1'b0;
              wrapped    <= 1'b0;
            end else begin
              inst       <= word;
              inst_valid <= 1'b1;
              pc         <= pc + ADDR_W'(1);
              if (issue_count != CNT_W'(DEPTH)) begin
                issue_count <= issue_count + CNT_W'(1);
              end
              if (pc == ADDR_W'(DEPTH - 1)) begin
                wrapped <= 1'b1;
              end
            end
          end
        end
        HALT: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_issue_unit.sv
// Bench for inst_issue_unit: a vector table for the basic and stalled runs,
// then hand-written sequences for the wrap, load-during-run, async reset,
// empty program and load-with-start corner cases.
module tb_inst_issue_unit;

  localparam logic [31:0] ADD = 32'h00208381;
  localparam logic [31:0] SUB = 32'h00209401;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [4:0]  issue_count;

  int passed = 0;
  int total  = 0;

  inst_issue_unit dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .busy(busy), .done(done),
    .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        stall;
    logic [31:0] inst;
    logic        valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] prog[16];

  function automatic vec_t mk(logic st, logic sl, logic [31:0] i, logic v,
                              logic [3:0] p, logic b, logic d, logic [4:0] c);
    vec_t r;
    r.start = st; r.stall = sl; r.inst = i; r.valid = v;
    r.pc = p; r.busy = b; r.done = d; r.cnt = c;
    return r;
  endfunction

  function automatic logic [31:0] mk_word(int i);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = 7'h00;
    case (i % 7)
      0: f3 = 3'd1;
      1: f3 = 3'd5;
      2: begin f3 = 3'd5; f7 = 7'h20; end
      3: f3 = 3'd2;
      4: f3 = 3'd4;
      5: f3 = 3'd6;
      default: f3 = 3'd7;
    endcase
    return {f7, 5'(i), 5'(i + 1), f3, 5'(i + 2), 7'h33};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load(logic [3:0] a, logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // inputs before edge -> expected outputs after edge
    vecs[0]  = mk(1, 0, 32'h0, 0, 4'd0, 1, 0, 5'd0);
    vecs[1]  = mk(0, 0, ADD,   1, 4'd1, 1, 0, 5'd1);
    vecs[2]  = mk(0, 0, SUB,   1, 4'd2, 1, 0, 5'd2);
    vecs[3]  = mk(0, 0, 32'h0, 0, 4'd2, 0, 1, 5'd2);
    vecs[4]  = mk(0, 0, 32'h0, 0, 4'd2, 0, 0, 5'd2);
    vecs[5]  = mk(1, 0, 32'h0, 0, 4'd0, 1, 0, 5'd0);
    vecs[6]  = mk(0, 0, ADD,   1, 4'd1, 1, 0, 5'd1);
    vecs[7]  = mk(1, 1, ADD,   1, 4'd1, 1, 0, 5'd1);
    vecs[8]  = mk(0, 1, ADD,   1, 4'd1, 1, 0, 5'd1);
    vecs[9]  = mk(0, 1, ADD,   1, 4'd1, 1, 0, 5'd1);
    vecs[10] = mk(1, 0, SUB,   1, 4'd2, 1, 0, 5'd2);
    vecs[11] = mk(0, 1, SUB,   1, 4'd2, 1, 0, 5'd2);
    vecs[12] = mk(0, 0, 32'h0, 0, 4'd2, 0, 1, 5'd2);
    vecs[13] = mk(1, 1, 32'h0, 0, 4'd2, 0, 0, 5'd2);
    vecs[14] = mk(0, 0, 32'h0, 0, 4'd2, 0, 0, 5'd2);
    for (int i = 0; i < 16; i++) prog[i] = mk_word(i);

    // reset values
    #12;
    chk("reset_outputs", 64'({inst, inst_valid, pc, busy, done, issue_count}), 64'(0));
    #1 reset = 1'b0;

    load(4'd0, ADD);
    load(4'd1, SUB);
    load(4'd2, 32'h0);

    // table-driven basic and stalled runs
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      stall = vecs[i].stall;
      tick();
      chk($sformatf("vec%0d", i),
          64'({inst, inst_valid, pc, busy, done, issue_count}),
          64'({vecs[i].inst, vecs[i].valid, vecs[i].pc, vecs[i].busy,
               vecs[i].done, vecs[i].cnt}));
    end
    start = 1'b0; stall = 1'b0;

    // full 16-word program wraps pc and halts after the last word
    for (int i = 0; i < 16; i++) load(4'(i), prog[i]);
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("wrap_issue%0d", c), 64'({inst, inst_valid, busy, issue_count}),
          64'({prog[c - 1], 1'b1, 1'b1, 5'(c)}));
    end
    tick();
    chk("wrap_done", 64'({inst_valid, done, busy, pc, issue_count}),
        64'({1'b0, 1'b1, 1'b0, 4'd0, 5'd16}));
    tick();
    chk("wrap_idle", 64'({done, busy}), 64'(0));

    // load_en during RUN is ignored
    load(4'd0, ADD);
    load(4'd1, SUB);
    load(4'd2, 32'h0);
    pulse_start();
    tick();
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'hFFFFFFFF;
    tick();
    chk("runload_c2", 64'({inst, inst_valid}), 64'({SUB, 1'b1}));
    tick();
    chk("runload_done", 64'(done), 64'(1));
    load_en = 1'b0;
    tick();
    pulse_start();
    tick();
    tick();
    chk("runload_reread", 64'({inst, inst_valid, issue_count}), 64'({SUB, 1'b1, 5'd2}));
    tick();
    tick();

    // async reset mid-run, then re-run from address 0
    pulse_start();
    tick();
    chk("pre_reset_add", 64'({inst, inst_valid}), 64'({ADD, 1'b1}));
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 64'({inst, inst_valid, pc, busy, done, issue_count}), 64'(0));
    #1 reset = 1'b0;
    pulse_start();
    tick();
    chk("rerun_c1", 64'({inst, inst_valid, pc}), 64'({ADD, 1'b1, 4'd1}));
    tick();
    chk("rerun_c2", 64'({inst, inst_valid, pc}), 64'({SUB, 1'b1, 4'd2}));
    tick();
    chk("rerun_done", 64'({done, inst_valid, issue_count}), 64'({1'b1, 1'b0, 5'd2}));
    tick();

    // empty program: marker at address 0
    load(4'd0, 32'h0);
    pulse_start();
    chk("empty_c0", 64'({inst_valid, busy, done}), 64'({1'b0, 1'b1, 1'b0}));
    tick();
    chk("empty_done", 64'({inst_valid, busy, done, issue_count, pc}),
        64'({1'b0, 1'b0, 1'b1, 5'd0, 4'd0}));
    tick();
    chk("empty_idle", 64'({inst_valid, done}), 64'(0));

    // load and start on the same edge: first fetch sees the new word
    load_en = 1'b1; load_addr = 4'd0; load_data = ADD; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    chk("loadstart_c1", 64'({inst, inst_valid}), 64'({ADD, 1'b1}));
    tick();
    tick();
    chk("loadstart_done", 64'({done, issue_count}), 64'({1'b1, 5'd2}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
